// File: rtl/song_seq_if.sv
// song_seq_if: synchronous song ROM bus; the sequencer drives the address, the ROM answers one cycle later
interface song_seq_if #(
  parameter int ROM_AW = 8,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4
);
  logic [ROM_AW-1:0]         rom_addr;
  logic [2*NOTE_W+DUR_W-1:0] rom_data;
  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/song_seq.sv
// song_seq: tempo-driven song ROM walker feeding note codes to two buzzers.
// Define SONG_LOOP_EN to restart the song from address 0 after its end marker.
module song_seq #(
  parameter int ROM_AW = 8,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tempo,
  input  logic              play,
  song_seq_if.master        rom,
  output logic [NOTE_W-1:0] note0,
  output logic [NOTE_W-1:0] note1,
  output logic              step,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_END} state_t;
  state_t             state, state_n;
  logic [ROM_AW-1:0]  addr, addr_n;
  logic [NOTE_W-1:0]  f0, f1, f0_n, f1_n, note0_n, note1_n, rd_n0, rd_n1;
  logic [DUR_W-1:0]   cnt, cnt_n, dlen, dlen_n, rd_dur;
  logic               tempo_q, tick, armed, armed_n, gap, hold;
  assign {rd_n0, rd_n1, rd_dur} = rom.rom_data;
  assign tick = tempo & ~tempo_q;
  assign rom.rom_addr = addr;
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    dlen_n  = dlen;
    f0_n    = f0;
    f1_n    = f1;
    armed_n = armed;
    case (state)
      S_IDLE: begin
        armed_n = armed | ~play;
        if (play && armed) begin
          state_n = S_FETCH;
          armed_n = 1'b0;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        if (rd_dur == '0) state_n = S_END;
        else begin
          state_n = S_PLAY;
          f0_n    = rd_n0;
          f1_n    = rd_n1;
          cnt_n   = rd_dur;
          dlen_n  = rd_dur;
        end
      end
      S_PLAY: begin
        if (tick) begin
          cnt_n = cnt - DUR_W'(1);
          if (cnt == DUR_W'(1)) begin
            state_n = S_FETCH;
            addr_n  = addr + ROM_AW'(1);
          end
        end
      end
      S_END:
`ifdef SONG_LOOP_EN
        state_n = play ? S_FETCH : S_IDLE;
`else
        state_n = S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE && !play) state_n = S_IDLE;
    if (state_n == S_IDLE || state_n == S_END) begin
      addr_n = '0;
      cnt_n  = '0;
      dlen_n = '0;
    end
    // last tick of a multi-tick note is silent so repeated notes stay distinct
    gap     = cnt_n == DUR_W'(1) && dlen_n >= DUR_W'(2);
    hold    = state_n == S_FETCH || state_n == S_LOAD;
    note0_n = hold ? note0 : (state_n == S_PLAY && !gap) ? f0_n : '0;
    note1_n = hold ? note1 : (state_n == S_PLAY && !gap) ? f1_n : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      cnt     <= '0;
      dlen    <= '0;
      f0      <= '0;
      f1      <= '0;
      note0   <= '0;
      note1   <= '0;
      step    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      tempo_q <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      cnt     <= cnt_n;
      dlen    <= dlen_n;
      f0      <= f0_n;
      f1      <= f1_n;
      note0   <= note0_n;
      note1   <= note1_n;
      step    <= state == S_LOAD && state_n == S_PLAY;
      done    <= state_n == S_END;
      busy    <= state_n != S_IDLE;
      tempo_q <= tempo;
      armed   <= armed_n;
    end
  end
endmodule

// File: doc/song_seq.md
# song_seq

Song sequencer sitting directly upstream of the two-channel buzzer tone logic. It counts rising edges of the timer's `tempo` output, walks a synchronous song ROM, and presents a pair of note codes (one per buzzer) for the programmed number of tempo ticks each. Its `note0`/`note1` outputs are consumed by the tone generator, which turns a nonzero code into a square wave and code 0 into silence.

## Interface
- `ROM_AW`, 8: song ROM address width.
- `NOTE_W`, 6: note code width; code 0 = rest.
- `DUR_W`, 4: duration field width, in tempo ticks; 0 = end-of-song marker.

- `clk` in 1: system clock, internal oscillator, 2.08 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `tempo` in 1: timer compare output, same clock domain; each rising edge is one tick.
- `play` in 1: level enable; low stops playback.
- `rom_addr` out ROM_AW: song ROM address.
- `rom_data` in 2*NOTE_W+DUR_W: ROM word, valid one cycle after `rom_addr`. Layout is `{note0, note1, dur}` with `dur` in the LSBs.
- `note0` out NOTE_W: note code for buzzer 0.
- `note1` out NOTE_W: note code for buzzer 1.
- `step` out 1: one-cycle pulse in the cycle a new note pair first appears on `note0`/`note1`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the end marker is reached.

## Operation
- Tick detect: `tempo_q` is `tempo` registered. `tick = tempo & ~tempo_q`.
- States:
  - IDLE: outputs 0, `rom_addr` 0. Leaves for FETCH when `play` is high and `armed` is set.
  - FETCH: `rom_addr` is driven. Always goes to LOAD next cycle.
  - LOAD: captures `rom_data`.
    - `dur == 0`: go to END.
    - Otherwise: `note0`/`note1` take the ROM fields, `cnt = dur`, `dlen = dur`, `step = 1`, go to PLAY.
  - PLAY: on `tick`, `cnt` decrements. On `tick` with `cnt == 1`, `rom_addr` increments and the state goes to FETCH.
  - END: `done = 1`, `rom_addr = 0`, outputs 0. Next state depends on the Configuration macro.
- Articulation gap: in PLAY, while `cnt == 1` and `dlen >= 2`, `note0`/`note1` read 0. This separates repeated notes. When `dlen == 1` there is no gap.
- Rest handling: a note code of 0 is passed through unchanged. The sequencer does not treat it specially.
- Address wrap: incrementing from `2^ROM_AW - 1` wraps to 0. No `done` pulse is generated by a wrap.
- `play` low in any non-IDLE state: next cycle IDLE, outputs 0, `rom_addr` 0, `cnt` 0, no `done`.
- `armed`: set in IDLE while `play` is low; cleared on leaving IDLE.
- Reset: asynchronous. State IDLE, `rom_addr` 0, `note0`/`note1` 0, `step`/`done`/`busy` 0, `cnt` 0, `tempo_q` 0, `armed` 1.

## Timing
- All outputs are registered.
- Start latency: `play` high sampled in IDLE at cycle N gives FETCH at N+1, LOAD at N+2, and notes plus `step` at N+3.
- Note-to-note: the tick that ends a note gives FETCH on the next cycle. The new notes appear 3 cycles after the tick edge is registered.
- Ticks arriving in FETCH, LOAD or END are not counted. The tempo period must be at least 4 clocks; the timer guarantees far more.
- `step` and `done` are never high in the same cycle.
- A tick in the same cycle as `play` falling: the stop wins.

## Configuration
- `SONG_LOOP_EN` defined: END goes to FETCH at address 0 if `play` is still high, otherwise to IDLE. The song repeats indefinitely.
- `SONG_LOOP_EN` undefined: END always goes to IDLE with `armed` cleared. `play` must go low and then high again to replay.

## Test plan
- Reset with `play = 1` and `tempo` toggling → all outputs 0 while `rst` is high. After release, notes appear on the 3rd cycle after the first sampled `play`.
- ROM {0x21,0x05,dur 3}, {0x00,0x10,dur 1}, end marker; ticks every 20 clocks:
  - `note0 = 0x21`, `note1 = 0x05` for 2 ticks, then 0/0 for 1 tick (gap).
  - Then `0x00`/`0x10` for 1 tick with no gap.
  - Then `done` pulses and the outputs go to 0.
- `play` dropped mid-note → next cycle IDLE, outputs 0, `rom_addr` 0, no `done`.
- Tick forced during FETCH → not counted; the note's duration is measured from LOAD onward.
- `SONG_LOOP_EN` defined, 2-entry song → after `done`, `rom_addr` returns to 0 and `step` fires again with the first pair.
  - Undefined: the block stays in IDLE until `play` goes 0 then 1.
- ROM with no end marker, `ROM_AW = 2` → address sequence 0,1,2,3,0 with no `done`.
